// File: rtl/trace_pkg.sv
// Shared types for the trace command sequencer: trace codes, per-channel ops,
// channel tags, sequencer states and the push-time decoder.
package trace_pkg;

   typedef enum logic [3:0] {
      CMD_DR    = 4'd0,
      CMD_DW    = 4'd1,
      CMD_IR    = 4'd2,
      CMD_INV   = 4'd3,
      CMD_RD    = 4'd4,
      CMD_WR    = 4'd5,
      CMD_RWIM  = 4'd6,
      CMD_CLEAR = 4'd8,
      CMD_PRINT = 4'd9
   } trace_cmd_e;

   typedef enum logic [1:0] {L1_DR = 2'd0, L1_DW = 2'd1, L1_IR = 2'd2} l1_op_e;
   typedef enum logic [1:0] {SNP_INV = 2'd0, SNP_RD = 2'd1, SNP_WR = 2'd2, SNP_RWIM = 2'd3} snp_op_e;
   typedef enum logic [1:0] {CTL_CLEAR = 2'd0, CTL_PRINT = 2'd1, CTL_STATS = 2'd2} ctl_op_e;
   typedef enum logic [1:0] {CH_L1 = 2'd0, CH_SNP = 2'd1, CH_CTL = 2'd2} chan_e;
   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_STATS = 2'd2, ST_DONE = 2'd3} seq_state_e;

   typedef struct packed {
      logic       legal;
      chan_e      ch;
      logic [1:0] op;
   } dec_t;

   function automatic dec_t decode_cmd(input logic [3:0] code);
      dec_t d;
      d = '{legal: 1'b0, ch: CH_L1, op: 2'd0};
      case (code)
         CMD_DR:    d = '{legal: 1'b1, ch: CH_L1,  op: L1_DR};
         CMD_DW:    d = '{legal: 1'b1, ch: CH_L1,  op: L1_DW};
         CMD_IR:    d = '{legal: 1'b1, ch: CH_L1,  op: L1_IR};
         CMD_INV:   d = '{legal: 1'b1, ch: CH_SNP, op: SNP_INV};
         CMD_RD:    d = '{legal: 1'b1, ch: CH_SNP, op: SNP_RD};
         CMD_WR:    d = '{legal: 1'b1, ch: CH_SNP, op: SNP_WR};
         CMD_RWIM:  d = '{legal: 1'b1, ch: CH_SNP, op: SNP_RWIM};
         CMD_CLEAR: d = '{legal: 1'b1, ch: CH_CTL, op: CTL_CLEAR};
         CMD_PRINT: d = '{legal: 1'b1, ch: CH_CTL, op: CTL_PRINT};
         default:   d = '{legal: 1'b0, ch: CH_L1,  op: 2'd0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/trace_cmd_sequencer_cmd_fifo.sv
// In-order command queue; head, pointers, count and full/empty are all flops,
// so a pushed entry is first visible the cycle after the push.
module cmd_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         empty,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          do_push, do_pop;

   // A pop never frees a slot for a push in the same cycle when full.
   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = empty_q;
   assign full      = full_q;

endmodule

// File: rtl/trace_cmd_sequencer.sv
// Buffers decoded trace records and dispatches them in order on L1 / snoop /
// control valid-ready channels, then issues the final stats command.
module trace_cmd_sequencer
   import trace_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_cmd,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              trace_end,
   output logic              l1_valid,
   input  logic              l1_ready,
   output logic [1:0]        l1_op,
   output logic [ADDR_W-1:0] l1_addr,
   output logic              snp_valid,
   input  logic              snp_ready,
   output logic [1:0]        snp_op,
   output logic [ADDR_W-1:0] snp_addr,
   output logic              ctl_valid,
   input  logic              ctl_ready,
   output logic [1:0]        ctl_op,
   input  logic [3:0]        stat_sel,
   output logic [CNT_W-1:0]  stat_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              done,
   output logic [1:0]        dbg_state
);

   // Every channel: valid stays high with op/addr stable until the cycle ready
   // is seen; the transfer happens on the clock edge where valid && ready.

   localparam int FW     = ADDR_W + 4;
   localparam int NCODES = 10;

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  stat_q [NCODES];
   logic [CNT_W-1:0]  stat_d [NCODES];
   logic [CNT_W-1:0]  err_q, err_d;

   dec_t              dec;
   logic              accept, push, pop;
   logic [FW-1:0]     head;
   logic              fifo_empty, fifo_full;
   chan_e             head_ch;
   logic [1:0]        head_op;
   logic [ADDR_W-1:0] head_addr;
   logic              l1_head, snp_head, ctl_head, in_stats;

   assign dec      = decode_cmd(in_cmd);
   assign in_ready = !reset && (state_q == ST_RUN) && !fifo_full;
   assign accept   = in_valid && in_ready;
   assign push     = accept && dec.legal;

   cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({dec.ch, dec.op, in_addr}),
      .pop       (pop),
      .head_data (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign head_ch   = chan_e'(head[FW-1 -: 2]);
   assign head_op   = head[ADDR_W +: 2];
   assign head_addr = head[ADDR_W-1:0];

   assign l1_head  = !fifo_empty && (head_ch == CH_L1);
   assign snp_head = !fifo_empty && (head_ch == CH_SNP);
   assign ctl_head = !fifo_empty && (head_ch == CH_CTL);
   assign in_stats = (state_q == ST_STATS);

   // Idle channels drive zero op/addr so nothing stale is visible.
   assign l1_valid  = l1_head;
   assign l1_op     = l1_head ? head_op : 2'd0;
   assign l1_addr   = l1_head ? head_addr : '0;
   assign snp_valid = snp_head;
   assign snp_op    = snp_head ? head_op : 2'd0;
   assign snp_addr  = snp_head ? head_addr : '0;
   assign ctl_valid = ctl_head || in_stats;
   assign ctl_op    = in_stats ? CTL_STATS : (ctl_head ? head_op : 2'd0);

   assign pop = (l1_head && l1_ready) || (snp_head && snp_ready) || (ctl_head && ctl_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (trace_end) state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_empty) state_d = ST_STATS;
         ST_STATS: if (ctl_ready) state_d = ST_DONE;
         default:  state_d = ST_DONE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NCODES; i++) begin
         stat_d[i] = stat_q[i];
         if (push && (in_cmd == 4'(i)) && (stat_q[i] != '1)) begin
            stat_d[i] = stat_q[i] + CNT_W'(1);
         end
      end
      err_d = err_q;
      if (accept && !dec.legal && (err_q != '1)) begin
         err_d = err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         for (int i = 0; i < NCODES; i++) stat_q[i] <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < NCODES; i++) stat_q[i] <= stat_d[i];
         err_q   <= err_d;
      end
   end

   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NCODES; i++) begin
         if (stat_sel == 4'(i)) stat_count = stat_q[i];
      end
   end

   assign err_count = err_q;
   assign done      = (state_q == ST_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// Directed bench for trace_cmd_sequencer: single-record vector table plus
// hand-written ordering, back-pressure, drain and reset sequences.
module tb_trace_cmd_sequencer;
   import trace_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 32;
   localparam int EW     = ADDR_W + 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_cmd;
   logic [ADDR_W-1:0] in_addr;
   logic              trace_end;
   logic              l1_valid, l1_ready;
   logic [1:0]        l1_op;
   logic [ADDR_W-1:0] l1_addr;
   logic              snp_valid, snp_ready;
   logic [1:0]        snp_op;
   logic [ADDR_W-1:0] snp_addr;
   logic              ctl_valid, ctl_ready;
   logic [1:0]        ctl_op;
   logic [3:0]        stat_sel;
   logic [CNT_W-1:0]  stat_count;
   logic [CNT_W-1:0]  err_count;
   logic              done;
   logic [1:0]        dbg_state;

   trace_cmd_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
      .trace_end(trace_end),
      .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
      .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
      .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_op(ctl_op),
      .stat_sel(stat_sel), .stat_count(stat_count), .err_count(err_count),
      .done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]        cmd;
      logic [ADDR_W-1:0] addr;
      logic              legal;
      logic [1:0]        ch;
      logic [1:0]        op;
   } vec_t;

   vec_t              vecs [14];
   logic [CNT_W-1:0]  exp_stat [16];
   logic [CNT_W-1:0]  exp_err;
   logic [EW-1:0]     exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic observe(output int nv, output logic [EW-1:0] seen);
      nv   = int'(l1_valid) + int'(snp_valid) + int'(ctl_valid);
      seen = '0;
      if (l1_valid)  seen = {CH_L1, l1_op, l1_addr};
      if (snp_valid) seen = {CH_SNP, snp_op, snp_addr};
      if (ctl_valid) seen = {CH_CTL, ctl_op, {ADDR_W{1'b0}}};
   endtask

   task automatic push_rec(input logic [3:0] cmd, input logic [ADDR_W-1:0] addr);
      tick();
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_addr  = addr;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic set_readies(input logic v);
      l1_ready  = v;
      snp_ready = v;
      ctl_ready = v;
   endtask

   initial begin
      int            nv;
      logic [EW-1:0] seen;
      logic [3:0]    c3 [9];
      logic [1:0]    ch3 [9];
      logic [1:0]    op3 [9];
      int            dispatched;
      logic          accepted;

      vecs[0]  = '{cmd: 4'd0,  addr: 32'h10, legal: 1'b1, ch: CH_L1,  op: 2'd0};
      vecs[1]  = '{cmd: 4'd1,  addr: 32'h14, legal: 1'b1, ch: CH_L1,  op: 2'd1};
      vecs[2]  = '{cmd: 4'd2,  addr: 32'h18, legal: 1'b1, ch: CH_L1,  op: 2'd2};
      vecs[3]  = '{cmd: 4'd3,  addr: 32'h20, legal: 1'b1, ch: CH_SNP, op: 2'd0};
      vecs[4]  = '{cmd: 4'd4,  addr: 32'h24, legal: 1'b1, ch: CH_SNP, op: 2'd1};
      vecs[5]  = '{cmd: 4'd5,  addr: 32'h28, legal: 1'b1, ch: CH_SNP, op: 2'd2};
      vecs[6]  = '{cmd: 4'd6,  addr: 32'h2C, legal: 1'b1, ch: CH_SNP, op: 2'd3};
      vecs[7]  = '{cmd: 4'd8,  addr: 32'h30, legal: 1'b1, ch: CH_CTL, op: 2'd0};
      vecs[8]  = '{cmd: 4'd9,  addr: 32'h34, legal: 1'b1, ch: CH_CTL, op: 2'd1};
      vecs[9]  = '{cmd: 4'd7,  addr: 32'h40, legal: 1'b0, ch: CH_L1,  op: 2'd0};
      vecs[10] = '{cmd: 4'd12, addr: 32'h44, legal: 1'b0, ch: CH_L1,  op: 2'd0};
      vecs[11] = '{cmd: 4'd10, addr: 32'h48, legal: 1'b0, ch: CH_L1,  op: 2'd0};
      vecs[12] = '{cmd: 4'd15, addr: 32'h4C, legal: 1'b0, ch: CH_L1,  op: 2'd0};
      vecs[13] = '{cmd: 4'd11, addr: 32'h50, legal: 1'b0, ch: CH_L1,  op: 2'd0};

      c3  = '{4'd0, 4'd3, 4'd8, 4'd1, 4'd4, 4'd9, 4'd2, 4'd5, 4'd6};
      ch3 = '{CH_L1, CH_SNP, CH_CTL, CH_L1, CH_SNP, CH_CTL, CH_L1, CH_SNP, CH_SNP};
      op3 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

      for (int i = 0; i < 16; i++) exp_stat[i] = '0;
      exp_err = '0;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_cmd    = '0;
      in_addr   = '0;
      trace_end = 1'b0;
      stat_sel  = '0;
      set_readies(1'b0);

      // Reset state
      #2;
      chk("rst_in_ready", in_ready, 0);
      observe(nv, seen);
      chk("rst_valids", nv, 0);
      chk("rst_ops_addr", {l1_op, snp_op, ctl_op, l1_addr, snp_addr}, 0);
      chk("rst_done", done, 0);
      chk("rst_state", dbg_state, ST_RUN);
      chk("rst_err", err_count, 0);
      chk("rst_stat", stat_count, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Single-record vectors
      foreach (vecs[k]) begin
         tick();
         in_valid = 1'b1;
         in_cmd   = vecs[k].cmd;
         in_addr  = vecs[k].addr;
         #1;
         chk($sformatf("vec%0d_in_ready", k), in_ready, 1);
         tick();
         in_valid = 1'b0;
         stat_sel = vecs[k].cmd;
         if (vecs[k].legal) exp_stat[vecs[k].cmd] = exp_stat[vecs[k].cmd] + 1;
         else exp_err = exp_err + 1;
         #1;
         observe(nv, seen);
         if (vecs[k].legal) begin
            chk($sformatf("vec%0d_nvalid", k), nv, 1);
            chk($sformatf("vec%0d_head", k), seen,
                {vecs[k].ch, vecs[k].op, (vecs[k].ch == CH_CTL) ? {ADDR_W{1'b0}} : vecs[k].addr});
         end else begin
            chk($sformatf("vec%0d_dropped", k), nv, 0);
         end
         chk($sformatf("vec%0d_stat", k), stat_count, exp_stat[vecs[k].cmd]);
         chk($sformatf("vec%0d_err", k), err_count, exp_err);
         if (vecs[k].legal) begin
            case (vecs[k].ch)
               CH_L1:   l1_ready = 1'b1;
               CH_SNP:  snp_ready = 1'b1;
               default: ctl_ready = 1'b1;
            endcase
            tick();
            set_readies(1'b0);
            #1;
            observe(nv, seen);
            chk($sformatf("vec%0d_consumed", k), nv, 0);
         end
      end

      // Back-to-back L1 with no fall-through
      tick();
      l1_ready = 1'b1;
      in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h100;
      #1;
      chk("t1_no_fallthru", l1_valid, 0);
      tick();
      in_cmd = 4'd1; in_addr = 32'h104;
      #1;
      observe(nv, seen);
      chk("t1_dr", seen, {CH_L1, 2'd0, 32'h100});
      tick();
      in_cmd = 4'd2; in_addr = 32'h108;
      #1;
      observe(nv, seen);
      chk("t1_dw", seen, {CH_L1, 2'd1, 32'h104});
      tick();
      in_valid = 1'b0;
      #1;
      observe(nv, seen);
      chk("t1_ir", seen, {CH_L1, 2'd2, 32'h108});
      tick();
      #1;
      observe(nv, seen);
      chk("t1_idle", nv, 0);
      l1_ready = 1'b0;

      // Snoop head blocks a later L1 record
      tick();
      in_valid = 1'b1; in_cmd = 4'd4; in_addr = 32'hA0;
      tick();
      in_cmd = 4'd0; in_addr = 32'hB0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         observe(nv, seen);
         chk($sformatf("t2_hold%0d", i), {nv[1:0], seen}, {2'd1, CH_SNP, 2'd1, 32'hA0});
         tick();
      end
      snp_ready = 1'b1;
      tick();
      snp_ready = 1'b0;
      #1;
      observe(nv, seen);
      chk("t2_l1_after", {nv[1:0], seen}, {2'd1, CH_L1, 2'd0, 32'hB0});
      l1_ready = 1'b1;
      tick();
      l1_ready = 1'b0;
      #1;
      observe(nv, seen);
      chk("t2_idle", nv, 0);

      // Fill to DEPTH with back-pressure, then release
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back({ch3[i], op3[i], (ch3[i] == CH_CTL) ? 32'h0 : 32'h1000 + 32'(i * 4)});
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         in_valid = 1'b1; in_cmd = c3[i]; in_addr = 32'h1000 + 32'(i * 4);
         #1;
         chk($sformatf("t3_ready%0d", i), in_ready, 1);
      end
      tick();
      in_cmd = c3[8]; in_addr = 32'h1000 + 32'd32;
      #1;
      chk("t3_full", in_ready, 0);
      set_readies(1'b1);
      #1;
      chk("t3_full_pop_no_slot", in_ready, 0);
      dispatched = 0;
      for (int cyc = 0; cyc < 24 && dispatched < 9; cyc++) begin
         observe(nv, seen);
         if (nv > 1) chk("t3_onehot", nv, 1);
         if (nv == 1) begin
            chk($sformatf("t3_order%0d", dispatched), seen, exp_q.pop_front());
            dispatched++;
         end
         accepted = in_valid && in_ready;
         tick();
         if (accepted) in_valid = 1'b0;
         #1;
      end
      chk("t3_count", dispatched, 9);
      chk("t3_in_valid_taken", in_valid, 0);
      set_readies(1'b0);

      // Reset with records queued and l1_valid high
      push_rec(4'd0, 32'h300);
      push_rec(4'd1, 32'h304);
      push_rec(4'd4, 32'h308);
      push_rec(4'd8, 32'h30C);
      #1;
      chk("t6_pre_l1_valid", l1_valid, 1);
      reset = 1'b1;
      stat_sel = 4'd0;
      #1;
      observe(nv, seen);
      chk("t6_valids", nv, 0);
      chk("t6_in_ready", in_ready, 0);
      chk("t6_stat", stat_count, 0);
      chk("t6_err", err_count, 0);
      for (int i = 0; i < 16; i++) exp_stat[i] = '0;
      exp_err = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("t6_in_ready_after", in_ready, 1);
      set_readies(1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         observe(nv, seen);
         chk($sformatf("t6_no_stale%0d", i), nv, 0);
      end
      set_readies(1'b0);

      // trace_end with three records queued
      push_rec(4'd2, 32'h200);
      push_rec(4'd5, 32'h204);
      push_rec(4'd9, 32'h208);
      trace_end = 1'b1;
      #1;
      chk("t5_ready_before_end", in_ready, 1);
      tick();
      trace_end = 1'b0;
      #1;
      chk("t5_ready_after_end", in_ready, 0);
      chk("t5_drain", dbg_state, ST_DRAIN);
      exp_q.delete();
      exp_q.push_back({CH_L1, 2'd2, 32'h200});
      exp_q.push_back({CH_SNP, 2'd2, 32'h204});
      exp_q.push_back({CH_CTL, 2'd1, 32'h0});
      exp_q.push_back({CH_CTL, 2'd2, 32'h0});
      set_readies(1'b1);
      for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
         observe(nv, seen);
         if (nv == 1) begin
            chk($sformatf("t5_seq%0d", 4 - exp_q.size()), seen, exp_q.pop_front());
            if (exp_q.size() == 0) chk("t5_done_before", done, 0);
         end
         tick();
         #1;
      end
      chk("t5_all_seen", exp_q.size(), 0);
      chk("t5_done", done, 1);
      chk("t5_state_done", dbg_state, ST_DONE);
      observe(nv, seen);
      chk("t5_quiet", nv, 0);
      chk("t5_in_ready_done", in_ready, 0);
      set_readies(1'b0);

      // trace_end with an empty FIFO
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      trace_end = 1'b1;
      tick();
      trace_end = 1'b0;
      #1;
      chk("t7_drain", dbg_state, ST_DRAIN);
      chk("t7_drain_ctl", ctl_valid, 0);
      tick();
      chk("t7_stats", {dbg_state, ctl_valid, ctl_op, done}, {ST_STATS, 1'b1, 2'd2, 1'b0});
      tick();
      chk("t7_stats_held", {ctl_valid, ctl_op, done}, {1'b1, 2'd2, 1'b0});
      ctl_ready = 1'b1;
      tick();
      ctl_ready = 1'b0;
      chk("t7_done", {done, ctl_valid}, {1'b1, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
